// File: rtl/sniffer_pkg.sv
// Shared types and constants for the multi-rule packet sniffer.
package sniffer_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    MAC  = 2'd1,
    IP   = 2'd2,
    PORT = 2'd3
  } rule_type_t;

  localparam logic [15:0] ETH_IPV4  = 16'h0800;
  localparam logic [7:0]  PROTO_TCP = 8'd6;
  localparam logic [7:0]  PROTO_UDP = 8'd17;

  // Word index (counted from sop) carrying each header field
  localparam logic [3:0] W_DST_MAC_HI = 4'd0;
  localparam logic [3:0] W_DST_MAC_LO = 4'd1;
  localparam logic [3:0] W_SRC_MAC_HI = 4'd1;
  localparam logic [3:0] W_SRC_MAC_LO = 4'd2;
  localparam logic [3:0] W_ETHERTYPE  = 4'd3;
  localparam logic [3:0] W_PROTO      = 4'd5;
  localparam logic [3:0] W_SRC_IP_HI  = 4'd6;
  localparam logic [3:0] W_SRC_IP_LO  = 4'd7;
  localparam logic [3:0] W_DST_IP_HI  = 4'd7;
  localparam logic [3:0] W_DST_IP_LO  = 4'd8;
  localparam logic [3:0] W_SRC_PORT   = 4'd8;
  localparam logic [3:0] W_DST_PORT   = 4'd9;

  // Minimum packet length (words) for a rule class to be able to match
  localparam logic [3:0] MIN_WORDS_MAC  = 4'd3;
  localparam logic [3:0] MIN_WORDS_IP   = 4'd9;
  localparam logic [3:0] MIN_WORDS_PORT = 4'd10;

  typedef struct packed {
    rule_type_t  typ;
    logic [47:0] value;
  } rule_t;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic [7:0]  proto;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
  } fields_t;

  typedef struct packed {
    logic mac;
    logic ip;
    logic port;
  } field_ok_t;

endpackage

// File: rtl/rule_matcher.sv
// Compares one programmed rule against the captured header fields.
module rule_matcher
  import sniffer_pkg::*;
(
  input  rule_t     rule,
  input  fields_t   fields,
  input  field_ok_t ok,
  output logic      match
);

  logic ip_hdr;
  logic l4_proto;

  // Field-valid flags gate every compare so stale header bytes never match
  always_comb begin
    ip_hdr   = ok.ip && (fields.ethertype == ETH_IPV4);
    l4_proto = (fields.proto == PROTO_TCP) || (fields.proto == PROTO_UDP);
    match    = 1'b0;
    case (rule.typ)
      MAC:     match = ok.mac && ((rule.value == fields.dst_mac) ||
                                  (rule.value == fields.src_mac));
      IP:      match = ip_hdr && ((rule.value[31:0] == fields.src_ip) ||
                                  (rule.value[31:0] == fields.dst_ip));
      PORT:    match = ok.port && ip_hdr && l4_proto &&
                       ((rule.value[15:0] == fields.src_port) ||
                        (rule.value[15:0] == fields.dst_port));
      default: match = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_rule_sniffer.sv
// Multi-rule Ethernet/IPv4 sniffer: captures header words, evaluates all
// rules at end of packet and writes one result record into a ring buffer.
module multi_rule_sniffer
  import sniffer_pkg::*;
#(
  parameter int          NUM_RULES    = 8,
  parameter int          CNT_W        = 32,
  parameter int          RESULT_DEPTH = 256,
  parameter logic [31:0] RESULT_BASE  = 32'h0000_0000,
  localparam int         RIDX_W       = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                data_in,
  input  logic                       sop,
  input  logic                       eop,
  input  logic                       valid,
  input  logic                       error,
  output logic                       ready,
  input  logic                       cfg_we,
  input  logic [RIDX_W-1:0]          cfg_idx,
  input  logic [1:0]                 cfg_type,
  input  logic [47:0]                cfg_value,
  output logic                       wr_en,
  output logic [31:0]                addr_out,
  output logic [31:0]                data_out,
  output logic [NUM_RULES*CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0]           pkt_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int RING_W = $clog2(RESULT_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_EVAL, S_WRITE} state_t;

  state_t                 state_q;
  logic [3:0]             wcnt_q;
  logic [15:0]            seq_q;
  logic [RING_W-1:0]      ring_idx_q;
  logic [NUM_RULES-1:0]   match_vec;
  logic [NUM_RULES-1:0]   match_p1;
  logic [15:0]            match16;
  logic [NUM_RULES-1:0]   cfg_sel;
  rule_type_t             rule_typ_q [NUM_RULES];
  logic [47:0]            rule_val_q [NUM_RULES];
  logic [CNT_W-1:0]       hit_q      [NUM_RULES];
  fields_t                fields_q;
  field_ok_t              ok;
  logic [3:0]             widx;
  logic                   take;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(n);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign ready = (state_q == S_IDLE) || (state_q == S_CAPTURE);
  // A sop word always restarts capture; other words only count inside a packet
  assign take  = valid && ready && (sop || (state_q == S_CAPTURE));
  assign widx  = sop ? 4'd0 : wcnt_q;

  assign ok.mac  = (wcnt_q >= MIN_WORDS_MAC);
  assign ok.ip   = (wcnt_q >= MIN_WORDS_IP);
  assign ok.port = (wcnt_q >= MIN_WORDS_PORT);

  // Header field capture straight from the stream (data, no reset)
  always_ff @(posedge clk) begin
    if (take) begin
      if (widx == W_DST_MAC_HI) fields_q.dst_mac[47:16]  <= data_in;
      if (widx == W_DST_MAC_LO) fields_q.dst_mac[15:0]   <= data_in[31:16];
      if (widx == W_SRC_MAC_HI) fields_q.src_mac[47:32]  <= data_in[15:0];
      if (widx == W_SRC_MAC_LO) fields_q.src_mac[31:0]   <= data_in;
      if (widx == W_ETHERTYPE)  fields_q.ethertype       <= data_in[31:16];
      if (widx == W_PROTO)      fields_q.proto           <= data_in[7:0];
      if (widx == W_SRC_IP_HI)  fields_q.src_ip[31:16]   <= data_in[15:0];
      if (widx == W_SRC_IP_LO)  fields_q.src_ip[15:0]    <= data_in[31:16];
      if (widx == W_DST_IP_HI)  fields_q.dst_ip[31:16]   <= data_in[15:0];
      if (widx == W_DST_IP_LO)  fields_q.dst_ip[15:0]    <= data_in[31:16];
      if (widx == W_SRC_PORT)   fields_q.src_port        <= data_in[15:0];
      if (widx == W_DST_PORT)   fields_q.dst_port        <= data_in[31:16];
    end
  end

  for (genvar i = 0; i < NUM_RULES; i++) begin : g_rule
    // An out-of-range cfg_idx selects no slot and is therefore ignored
    assign cfg_sel[i] = cfg_we && (cfg_idx == RIDX_W'(i));
    assign hit_cnt[i*CNT_W +: CNT_W] = hit_q[i];

    rule_matcher u_match (
      .rule   ('{typ: rule_typ_q[i], value: rule_val_q[i]}),
      .fields (fields_q),
      .ok     (ok),
      .match  (match_vec[i])
    );
  end

  // Zero-extend the match vector into the 16-bit result field
  always_comb begin
    match16                = '0;
    match16[NUM_RULES-1:0] = match_vec;
  end

  // Rule type registers; reset turns every slot off
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RULES; i++) rule_typ_q[i] <= OFF;
    end else begin
      for (int i = 0; i < NUM_RULES; i++)
        if (cfg_sel[i]) rule_typ_q[i] <= rule_type_t'(cfg_type);
    end
  end

  // Rule match values (data, no reset; gated by the type register)
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RULES; i++)
      if (cfg_sel[i]) rule_val_q[i] <= cfg_value;
  end

  // Per-rule saturating hit counters; a config write clears and beats increment
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RULES; i++) hit_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RULES; i++) begin
        if (cfg_sel[i])
          hit_q[i] <= '0;
        else if ((state_q == S_WRITE) && match_p1[i])
          hit_q[i] <= sat_add(hit_q[i], 2'd1);
      end
    end
  end

  // Packet FSM with registered result-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      seq_q      <= '0;
      ring_idx_q <= '0;
      match_p1   <= '0;
      wr_en      <= 1'b0;
      addr_out   <= '0;
      data_out   <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state_q)
        S_IDLE, S_CAPTURE: begin
          if (take) begin
            wcnt_q   <= sop ? 4'd1 : ((wcnt_q == 4'hF) ? 4'hF : wcnt_q + 4'd1);
            // A sop inside a packet aborts it; eop with error discards this one
            drop_cnt <= sat_add(drop_cnt,
                                {1'b0, (state_q == S_CAPTURE) && sop} +
                                {1'b0, eop && error});
            if (eop) state_q <= error ? S_IDLE : S_EVAL;
            else     state_q <= S_CAPTURE;
          end
        end
        S_EVAL: begin
          match_p1 <= match_vec;
          wr_en    <= 1'b1;
          addr_out <= RESULT_BASE + 32'({ring_idx_q, 2'b00});
          data_out <= {seq_q, match16};
          state_q  <= S_WRITE;
        end
        S_WRITE: begin
          seq_q      <= seq_q + 16'd1;
          ring_idx_q <= ring_idx_q + 1'b1;
          pkt_cnt    <= sat_add(pkt_cnt, 2'd1);
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_rule_sniffer.sv
// Directed bench for multi_rule_sniffer (4-entry ring, 4-bit counters).
module tb_multi_rule_sniffer;
  localparam int          NR    = 8;
  localparam int          CW    = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam logic [47:0] MAC_A = 48'h0011_2233_4455;

  logic        clk = 1'b0;
  logic        rst, sop, eop, valid, error, ready, cfg_we, wr_en;
  logic [31:0] data_in, addr_out, data_out;
  logic [2:0]  cfg_idx;
  logic [1:0]  cfg_type;
  logic [47:0] cfg_value;
  logic [NR*CW-1:0] hit_cnt;
  logic [CW-1:0]    pkt_cnt, drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int e_seq = 0, e_idx = 0;
  int h0 = 0, h1 = 0, h2 = 0, pc = 0, dc = 0;
  logic [31:0] pkt [16];

  always #5 clk = ~clk;

  multi_rule_sniffer #(.NUM_RULES(NR), .CNT_W(CW), .RESULT_DEPTH(4),
                       .RESULT_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .sop(sop), .eop(eop),
    .valid(valid), .error(error), .ready(ready), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_type(cfg_type), .cfg_value(cfg_value),
    .wr_en(wr_en), .addr_out(addr_out), .data_out(data_out),
    .hit_cnt(hit_cnt), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt));

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, " hit0"}, 64'(hit_cnt[0*CW +: CW]), 64'(sat(h0)));
    check({tag, " hit1"}, 64'(hit_cnt[1*CW +: CW]), 64'(sat(h1)));
    check({tag, " hit2"}, 64'(hit_cnt[2*CW +: CW]), 64'(sat(h2)));
    check({tag, " pkt"},  64'(pkt_cnt),  64'(sat(pc)));
    check({tag, " drop"}, 64'(drop_cnt), 64'(sat(dc)));
  endtask

  task automatic build(input logic [47:0] dm, input logic [47:0] sm,
                       input logic [15:0] et, input logic [7:0] pr,
                       input logic [31:0] si, input logic [31:0] di,
                       input logic [15:0] sp, input logic [15:0] dp);
    pkt[0] = dm[47:16];
    pkt[1] = {dm[15:0], sm[47:32]};
    pkt[2] = sm[31:0];
    pkt[3] = {et, 16'h4500};
    pkt[4] = 32'h0032_1234;
    pkt[5] = {16'h4000, 8'h40, pr};
    pkt[6] = {16'hBEEF, si[31:16]};
    pkt[7] = {si[15:0], di[31:16]};
    pkt[8] = {di[15:0], sp};
    pkt[9] = {dp, 16'h0000};
    for (int i = 10; i < 16; i++) pkt[i] = 32'hA5A5_0000 + 32'(i);
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [1:0] t, input logic [47:0] v);
    cfg_we = 1'b1; cfg_idx = idx; cfg_type = t; cfg_value = v;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Streams words 0..n-1 of pkt; eop on the last word only when close is set
  task automatic send_words(input int n, input logic close, input logic err);
    for (int i = 0; i < n; i++) begin
      valid = 1'b1; data_in = pkt[i];
      sop = (i == 0); eop = close && (i == n - 1); error = err && eop;
      @(posedge clk); #1;
    end
    valid = 1'b0; sop = 1'b0; eop = 1'b0; error = 1'b0;
  endtask

  task automatic send_pkt(input string tag, input int n, input logic err,
                          input logic [15:0] exp_match, input logic cfg_in_write);
    send_words(n, 1'b1, err);
    check({tag, " wr_en+1"}, 64'(wr_en), 64'(0));
    check({tag, " ready+1"}, 64'(ready), 64'(err));
    @(posedge clk); #1;
    if (err) begin
      check({tag, " wr_en+2"}, 64'(wr_en), 64'(0));
    end else begin
      check({tag, " wr_en+2"}, 64'(wr_en), 64'(1));
      check({tag, " addr"}, 64'(addr_out), 64'(BASE + 32'(4 * e_idx)));
      check({tag, " data"}, 64'(data_out), 64'({e_seq[15:0], exp_match}));
      e_seq++; e_idx = (e_idx + 1) % 4;
      if (cfg_in_write) begin
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_type = 2'd1; cfg_value = MAC_A;
      end
    end
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check({tag, " wr_en+3"}, 64'(wr_en), 64'(0));
    check({tag, " ready+3"}, 64'(ready), 64'(1));
  endtask

  initial begin
    rst = 1'b1; sop = 0; eop = 0; valid = 0; error = 0; data_in = '0;
    cfg_we = 0; cfg_idx = '0; cfg_type = '0; cfg_value = '0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    check("reset ready", 64'(ready), 64'(1));
    check("reset wr_en", 64'(wr_en), 64'(0));
    check("reset addr", 64'(addr_out), 64'(0));
    check("reset data", 64'(data_out), 64'(0));
    check("reset hits", 64'(hit_cnt), 64'(0));
    check_counts("reset");

    // MAC rule, 64-byte frame with matching dst MAC
    cfg(3'd0, 2'd1, MAC_A);
    build(MAC_A, 48'h0A0B_0C0D_0E0F, 16'h0800, 8'd6, 32'hC0A8_0005,
          32'h0A00_0001, 16'd1234, 16'd443);
    send_pkt("mac", 16, 1'b0, 16'h0001, 1'b0);
    h0 = 1; pc = 1; check_counts("mac");

    // IP and PORT rules, TCP packet
    cfg(3'd1, 2'd2, 48'h0000_C0A8_0001);
    cfg(3'd2, 2'd3, 48'd80);
    build(48'h0200_0000_0001, 48'h0200_0000_0002, 16'h0800, 8'd6,
          32'hC0A8_0001, 32'h0A00_0002, 16'd5000, 16'd80);
    send_pkt("tcp", 16, 1'b0, 16'h0006, 1'b0);
    h1 = 1; h2 = 1; pc = 2; check_counts("tcp");

    // Same packet as ICMP: port rule must not fire
    build(48'h0200_0000_0001, 48'h0200_0000_0002, 16'h0800, 8'd1,
          32'hC0A8_0001, 32'h0A00_0002, 16'd5000, 16'd80);
    send_pkt("icmp", 16, 1'b0, 16'h0002, 1'b0);
    h1 = 2; pc = 3; check_counts("icmp");

    // Errored packet is dropped with no write and seq unchanged
    send_pkt("err", 16, 1'b1, 16'h0000, 1'b0);
    dc = 1; check_counts("err");

    // Length boundaries: MAC needs 3 words, IP 9, PORT 10
    build(MAC_A, 48'h0A0B_0C0D_0E0F, 16'h0800, 8'd6, 32'hC0A8_0005,
          32'h0A00_0001, 16'd1234, 16'd443);
    send_pkt("2w", 2, 1'b0, 16'h0000, 1'b0);
    pc = 4; check_counts("2w");
    send_pkt("3w", 3, 1'b0, 16'h0001, 1'b0);
    h0 = 2; pc = 5; check_counts("3w");
    build(48'h0200_0000_0001, 48'h0200_0000_0002, 16'h0800, 8'd6,
          32'hC0A8_0001, 32'h0A00_0002, 16'd5000, 16'd80);
    send_pkt("8w", 8, 1'b0, 16'h0000, 1'b0);
    pc = 6; check_counts("8w");
    send_pkt("9w", 9, 1'b0, 16'h0002, 1'b0);
    h1 = 3; pc = 7; check_counts("9w");
    send_pkt("10w", 10, 1'b0, 16'h0006, 1'b0);
    h1 = 4; h2 = 2; pc = 8; check_counts("10w");

    // sop mid-packet aborts the first packet and restarts on the new one
    send_words(4, 1'b0, 1'b0);
    build(MAC_A, 48'h0A0B_0C0D_0E0F, 16'h0800, 8'd6, 32'hC0A8_0005,
          32'h0A00_0001, 16'd1234, 16'd443);
    send_pkt("resop", 16, 1'b0, 16'h0001, 1'b0);
    h0 = 3; pc = 9; dc = 2; check_counts("resop");

    // Saturation of 4-bit hit and packet counters
    for (int k = 0; k < 13; k++) begin
      send_pkt("sat", 16, 1'b0, 16'h0001, 1'b0);
      h0++; pc++;
      check_counts("sat");
    end

    // Config write during WRITE clears the slot instead of incrementing
    send_pkt("clr", 16, 1'b0, 16'h0001, 1'b1);
    h0 = 0; pc++; check_counts("clr");

    // Reset in the middle of a capture
    send_words(5, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    h0 = 0; h1 = 0; h2 = 0; pc = 0; dc = 0; e_seq = 0; e_idx = 0;
    check("rst ready", 64'(ready), 64'(1));
    check("rst wr_en", 64'(wr_en), 64'(0));
    check("rst hits", 64'(hit_cnt), 64'(0));
    check_counts("rst");
    send_pkt("post-rst", 16, 1'b0, 16'h0000, 1'b0);
    pc = 1; check_counts("post-rst");
    cfg(3'd0, 2'd1, MAC_A);
    send_pkt("post-cfg", 16, 1'b0, 16'h0001, 1'b0);
    h0 = 1; pc = 2; check_counts("post-cfg");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
